// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: register map,
// CTRL/STATUS bit positions and loader FSM states.
package fpga_cfg_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_FULL_BIT = 2;
  localparam int STAT_OVF_BIT  = 3;
  localparam int STAT_LVL_LSB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fpga_cfg_fifo.sv
// Show-ahead synchronous FIFO with flush; a push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module fpga_cfg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok_s, pop_ok_s;

  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok_s && !pop_ok_s)      level_q <= level_q + LVL_W'(1);
      else if (pop_ok_s && !push_ok_s) level_q <= level_q - LVL_W'(1);
      else                             level_q <= level_q;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone slave that streams buffered bitstream words into N parallel
// serial config chains and holds the fabric in configuration until done.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int          N_CHAINS   = 4,
  parameter int          CHAIN_LEN  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                cfg_shift_o,
  output logic [N_CHAINS-1:0] cfg_data_o,
  output logic                cfg_done_o,
  output logic                busy_o
);

  localparam int STEPS  = 32 / N_CHAINS;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [31:0]         word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                overflow_q, overflow_d;
  logic                shift_q, shift_d;
  logic [N_CHAINS-1:0] data_q, data_d;
  logic                ack_q;
  logic [31:0]         rdat_q;

  logic             req_s, wr_s, rd_s, ctrl_wr_s, data_wr_s;
  logic             start_s, abort_s, push_s, pop_s;
  logic             shift_s, last_step_s, final_shift_s, count_full_s;
  logic [1:0]       offset_s;
  logic [31:0]      fifo_rdata_s, status_s, rdata_s, lvl_ext_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic [3:0]       lvl_sat_s;

  logic unused_sel_s;
  assign unused_sel_s = ^wbs_sel_i;

  assign req_s     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]) && !ack_q;
  assign wr_s      = req_s && wbs_we_i;
  assign rd_s      = req_s && !wbs_we_i;
  assign offset_s  = wbs_adr_i[3:2];
  assign ctrl_wr_s = wr_s && (offset_s == REG_CTRL);
  assign data_wr_s = wr_s && (offset_s == REG_DATA);
  assign abort_s   = ctrl_wr_s && wbs_dat_i[CTRL_ABORT_BIT];
  assign start_s   = ctrl_wr_s && wbs_dat_i[CTRL_START_BIT] && !abort_s;
  assign push_s    = data_wr_s && (state_q != ST_DONE);

  assign count_full_s  = (count_q == CNT_W'(CHAIN_LEN));
  assign shift_s       = (state_q == ST_LOAD) && word_valid_q && !count_full_s;
  assign last_step_s   = (step_q == STEP_W'(STEPS - 1));
  assign final_shift_s = shift_s && (count_q == CNT_W'(CHAIN_LEN - 1));
  // The word feeding the final shift is never refilled so the FIFO keeps its tail in DONE.
  assign pop_s = (state_q == ST_LOAD) && !fifo_empty_s && !abort_s && !count_full_s &&
                 !final_shift_s && (!word_valid_q || (shift_s && last_step_s));

  fpga_cfg_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (abort_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wbs_dat_i),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    step_d       = step_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q ||
                   (data_wr_s && ((state_q == ST_DONE) || (fifo_full_s && !pop_s)));
    shift_d      = 1'b0;
    data_d       = '0;
    if (abort_s) begin
      state_d      = ST_IDLE;
      count_d      = '0;
      step_d       = '0;
      word_d       = 32'd0;
      word_valid_d = 1'b0;
    end else if (start_s && (state_q != ST_LOAD)) begin
      state_d      = ST_LOAD;
      count_d      = '0;
      step_d       = '0;
      word_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (count_full_s) begin
        state_d      = ST_DONE;
        step_d       = '0;
        word_valid_d = 1'b0;
      end else begin
        if (shift_s) begin
          shift_d = 1'b1;
          data_d  = word_q[N_CHAINS-1:0];
          word_d  = word_q >> N_CHAINS;
          count_d = count_q + CNT_W'(1);
          if (last_step_s) begin
            step_d       = '0;
            word_valid_d = 1'b0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          shift_d = 1'b0;
        end
        if (pop_s) begin
          word_d       = fifo_rdata_s;
          word_valid_d = 1'b1;
          step_d       = '0;
        end else begin
          word_valid_d = word_valid_d;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      step_q       <= '0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      shift_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      step_q       <= step_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
    end
  end

  assign lvl_ext_s = 32'(fifo_level_s);
  assign lvl_sat_s = (lvl_ext_s > 32'd15) ? 4'hF : lvl_ext_s[3:0];

  always_comb begin
    status_s                          = 32'd0;
    status_s[STAT_BUSY_BIT]           = (state_q == ST_LOAD);
    status_s[STAT_DONE_BIT]           = (state_q == ST_DONE);
    status_s[STAT_FULL_BIT]           = fifo_full_s;
    status_s[STAT_OVF_BIT]            = overflow_q;
    status_s[STAT_LVL_LSB +: 4]       = lvl_sat_s;
  end

  always_comb begin
    case (offset_s)
      REG_STATUS: rdata_s = status_s;
      REG_COUNT:  rdata_s = 32'(count_q);
      default:    rdata_s = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= 32'd0;
    end else begin
      ack_q  <= req_s;
      rdat_q <= rd_s ? rdata_s : 32'd0;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign cfg_shift_o = shift_q;
  assign cfg_data_o  = data_q;
  assign cfg_done_o  = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_LOAD);

endmodule
